// File: rtl/usb_fs_pkg.sv
// usb_fs_pkg: shared constants for the full-speed USB transmit/receive paths.
//   - 4-bit PID codes for handshake and data packets
//   - line state codes, packed as {dp, dn}
//   - CRC16 polynomial and initial value
//   - transmit serializer state encoding
package usb_fs_pkg;

  localparam logic [3:0] PidAck   = 4'b0010;
  localparam logic [3:0] PidNak   = 4'b1010;
  localparam logic [3:0] PidStall = 4'b1110;
  localparam logic [3:0] PidData0 = 4'b0011;
  localparam logic [3:0] PidData1 = 4'b1011;

  localparam logic [1:0] LineJ   = 2'b10;
  localparam logic [1:0] LineK   = 2'b01;
  localparam logic [1:0] LineSe0 = 2'b00;

  localparam logic [15:0] Crc16Poly = 16'h8005;
  localparam logic [15:0] Crc16Init = 16'hFFFF;

  typedef logic [2:0] tx_state_t;
  localparam tx_state_t StIdle = 3'd0;
  localparam tx_state_t StSync = 3'd1;
  localparam tx_state_t StPid  = 3'd2;
  localparam tx_state_t StData = 3'd3;
  localparam tx_state_t StCrc  = 3'd4;
  localparam tx_state_t StEop  = 3'd5;

endpackage

// File: rtl/usb_fs_crc16.sv
// usb_fs_crc16: bit-serial CRC16 (poly 0x8005, init 0xFFFF), shared by TX and RX.
// Ports:
//   clk, reset  clock and asynchronous active-high reset
//   clear       reload the initial value (takes priority over enable)
//   enable      fold din into the CRC this cycle
//   din         serial data bit
//   crc         current CRC register value
module usb_fs_crc16
  import usb_fs_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        enable,
  input  logic        din,
  output logic [15:0] crc
);

  logic [15:0] crc_q;
  logic        fb;

  assign fb = din ^ crc_q[15];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      crc_q <= Crc16Init;
    end else if (clear) begin
      crc_q <= Crc16Init;
    end else if (enable) begin
      crc_q <= {crc_q[14:0], 1'b0} ^ (fb ? Crc16Poly : 16'h0000);
    end
  end

  assign crc = crc_q;

endmodule

// File: rtl/usb_fs_tx_serializer.sv
// usb_fs_tx_serializer: full-speed USB packet transmitter.
// Sends SYNC, PID, optional payload + CRC16 and EOP with bit stuffing and NRZI.
// Ports:
//   clk, reset              clock, asynchronous active-high reset
//   tx_pkt_start, tx_pid    packet request strobe and PID (ignored while busy)
//   tx_data_avail, tx_data  upstream payload byte and "more bytes" flag
//   tx_data_get             one-cycle byte consume strobe
//   tx_pkt_end              one-cycle strobe as the bus is released
//   usb_tx_en               D+/D- driver enable
//   usb_dp_tx, usb_dn_tx    line state
//   tx_busy                 packet in progress (accept through tx_pkt_end)
// Optional: define USB_FS_TX_PKT_CNT_EN to add tx_pkt_count[15:0], a wrapping
// count of completed packets.
module usb_fs_tx_serializer
  import usb_fs_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tx_pkt_start,
  input  logic [3:0] tx_pid,
  input  logic       tx_data_avail,
  output logic       tx_data_get,
  input  logic [7:0] tx_data,
  output logic       tx_pkt_end,
  output logic       usb_tx_en,
  output logic       usb_dp_tx,
  output logic       usb_dn_tx,
  output logic       tx_busy
`ifdef USB_FS_TX_PKT_CNT_EN
  ,
  output logic [15:0] tx_pkt_count
`endif
);

  localparam int unsigned TW = $clog2(CLKS_PER_BIT);

  tx_state_t   state_q, state_d;
  logic [TW-1:0] clk_cnt_q, clk_cnt_d;
  logic [3:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  sr_q, sr_d;
  logic [2:0]  ones_q, ones_d;
  logic        stuff_q, stuff_d;
  logic [3:0]  pid_q, pid_d;
  logic [1:0]  line_q, line_d;
  logic        tx_en_q, tx_en_d;
  logic        get_q, get_d;
  logic        end_q, end_d;

  logic        crc_clear, crc_en, crc_din;
  logic [15:0] crc;
  logic        bit_end, cur_bit, stuff_due, next_bit;

  usb_fs_crc16 u_crc16 (
    .clk    (clk),
    .reset  (reset),
    .clear  (crc_clear),
    .enable (crc_en),
    .din    (crc_din),
    .crc    (crc)
  );

  assign bit_end = (clk_cnt_q == TW'(CLKS_PER_BIT - 1));

  // Bit currently on the line; stuff bits hold bit_idx/sr, so they override.
  assign cur_bit = stuff_q ? 1'b0 :
                   (state_q == StCrc) ? ~crc[4'd15 - bit_idx_q] : sr_q[0];

  // A sixth consecutive 1 ending now means a stuffed 0 comes next.
  assign stuff_due = ((state_q == StPid) || (state_q == StData) || (state_q == StCrc)) &&
                     cur_bit && (ones_q == 3'd5);

  always_comb begin
    state_d   = state_q;
    clk_cnt_d = clk_cnt_q;
    bit_idx_d = bit_idx_q;
    sr_d      = sr_q;
    ones_d    = ones_q;
    stuff_d   = stuff_q;
    pid_d     = pid_q;
    line_d    = line_q;
    tx_en_d   = tx_en_q;
    get_d     = 1'b0;
    end_d     = 1'b0;
    crc_clear = 1'b0;
    crc_en    = 1'b0;
    next_bit  = 1'b1;

    if (state_q == StIdle) begin
      clk_cnt_d = '0;
      if (tx_pkt_start && !end_q) begin
        pid_d     = tx_pid;
        state_d   = StSync;
        bit_idx_d = 4'd0;
        sr_d      = 8'h80;  // SYNC 0000_0001, LSB first
        ones_d    = 3'd0;
        stuff_d   = 1'b0;
        tx_en_d   = 1'b1;
        line_d    = LineK;  // line starts at J; the first SYNC bit is 0
      end
    end else if (!bit_end) begin
      clk_cnt_d = clk_cnt_q + TW'(1);
    end else begin
      clk_cnt_d = '0;
      ones_d    = cur_bit ? ones_q + 3'd1 : 3'd0;
      if (stuff_due) begin
        stuff_d = 1'b1;
      end else begin
        stuff_d = 1'b0;
        unique case (state_q)
          StSync: begin
            if (bit_idx_q == 4'd7) begin
              state_d   = StPid;
              bit_idx_d = 4'd0;
              sr_d      = {~pid_q, pid_q};
              crc_clear = 1'b1;
            end else begin
              bit_idx_d = bit_idx_q + 4'd1;
              sr_d      = sr_q >> 1;
            end
          end
          StPid, StData: begin
            if (bit_idx_q != 4'd7) begin
              bit_idx_d = bit_idx_q + 4'd1;
              sr_d      = sr_q >> 1;
            end else if ((state_q == StPid) && (pid_q[1:0] != 2'b11)) begin
              state_d   = StEop;
              bit_idx_d = 4'd0;
            end else if (tx_data_avail) begin
              state_d   = StData;
              bit_idx_d = 4'd0;
              sr_d      = tx_data;
              get_d     = 1'b1;
            end else begin
              state_d   = StCrc;
              bit_idx_d = 4'd0;
            end
          end
          StCrc: begin
            if (bit_idx_q == 4'd15) begin
              state_d   = StEop;
              bit_idx_d = 4'd0;
            end else begin
              bit_idx_d = bit_idx_q + 4'd1;
            end
          end
          StEop: begin
            if (bit_idx_q == 4'd2) begin
              state_d = StIdle;
              tx_en_d = 1'b0;
              end_d   = 1'b1;
            end else begin
              bit_idx_d = bit_idx_q + 4'd1;
            end
          end
          default: state_d = StIdle;
        endcase
      end

      // Drive the line for the bit that starts now.
      if (state_d == StEop) begin
        line_d = (bit_idx_d == 4'd2) ? LineJ : LineSe0;
      end else if (state_d == StIdle) begin
        line_d = LineJ;
      end else begin
        next_bit = stuff_d ? 1'b0 :
                   (state_d == StCrc) ? ~crc[4'd15 - bit_idx_d] : sr_d[0];
        if (!next_bit) begin
          line_d = ~line_q;  // J <-> K
        end
        // Payload bits fold into the CRC as they start, so it is final by CRC entry.
        crc_en = (state_d == StData) && !stuff_d;
      end
    end
  end

  assign crc_din = sr_d[0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      clk_cnt_q <= '0;
      bit_idx_q <= 4'd0;
      sr_q      <= 8'h00;
      ones_q    <= 3'd0;
      stuff_q   <= 1'b0;
      pid_q     <= 4'd0;
      line_q    <= LineJ;
      tx_en_q   <= 1'b0;
      get_q     <= 1'b0;
      end_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      clk_cnt_q <= clk_cnt_d;
      bit_idx_q <= bit_idx_d;
      sr_q      <= sr_d;
      ones_q    <= ones_d;
      stuff_q   <= stuff_d;
      pid_q     <= pid_d;
      line_q    <= line_d;
      tx_en_q   <= tx_en_d;
      get_q     <= get_d;
      end_q     <= end_d;
    end
  end

  assign usb_tx_en   = tx_en_q;
  assign usb_dp_tx   = line_q[1];
  assign usb_dn_tx   = line_q[0];
  assign tx_data_get = get_q;
  assign tx_pkt_end  = end_q;
  assign tx_busy     = (state_q != StIdle) || end_q;

`ifdef USB_FS_TX_PKT_CNT_EN
  logic [15:0] pkt_cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pkt_cnt_q <= 16'h0000;
    end else if (end_q) begin
      pkt_cnt_q <= pkt_cnt_q + 16'd1;
    end
  end

  assign tx_pkt_count = pkt_cnt_q;
`endif

endmodule

// File: tb/tb_usb_fs_tx_serializer.sv
// tb_usb_fs_tx_serializer: scoreboard bench. Stimulus queues expected decoded
// bytes and per-packet figures; a line monitor NRZI-decodes and destuffs the
// bus, then pops and compares.
module tb_usb_fs_tx_serializer;
  import usb_fs_pkg::*;

  localparam int Cpb = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tx_pkt_start = 1'b0;
  logic [3:0] tx_pid = 4'd0;
  logic       tx_data_avail = 1'b0;
  logic       tx_data_get;
  logic [7:0] tx_data = 8'h00;
  logic       tx_pkt_end;
  logic       usb_tx_en;
  logic       usb_dp_tx;
  logic       usb_dn_tx;
  logic       tx_busy;
`ifdef USB_FS_TX_PKT_CNT_EN
  logic [15:0] tx_pkt_count;
`endif

  usb_fs_tx_serializer #(.CLKS_PER_BIT(Cpb)) dut (
    .clk           (clk),
    .reset         (reset),
    .tx_pkt_start  (tx_pkt_start),
    .tx_pid        (tx_pid),
    .tx_data_avail (tx_data_avail),
    .tx_data_get   (tx_data_get),
    .tx_data       (tx_data),
    .tx_pkt_end    (tx_pkt_end),
    .usb_tx_en     (usb_tx_en),
    .usb_dp_tx     (usb_dp_tx),
    .usb_dn_tx     (usb_dn_tx),
`ifdef USB_FS_TX_PKT_CNT_EN
    .tx_pkt_count  (tx_pkt_count),
`endif
    .tx_busy       (tx_busy)
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    int nbytes;
    int gets;
    int clks;
    int stuffs;
  } exp_pkt_t;

  logic [7:0] byte_q[$];
  exp_pkt_t   pkt_q[$];

  int total = 0;
  int bad = 0;
  int end_cnt = 0;
  int exp_ends = 0;
  bit abort_mode = 1'b0;

  logic [7:0] mem [64];
  int up_n = 0;
  int pkt_seq = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference CRC16 over payload bytes, LSB first.
  function automatic logic [15:0] crc16_model(input logic [7:0] d[$]);
    logic [15:0] c;
    logic fb;
    c = 16'hFFFF;
    foreach (d[j]) begin
      for (int i = 0; i < 8; i++) begin
        fb = d[j][i] ^ c[15];
        c  = {c[14:0], 1'b0} ^ (fb ? 16'h8005 : 16'h0000);
      end
    end
    return c;
  endfunction

  // Stuff bits for PID..CRC bytes; SYNC leaves one 1 pending.
  function automatic int count_stuffs(input logic [7:0] d[$]);
    int ones;
    int n;
    ones = 1;
    n = 0;
    foreach (d[j]) begin
      for (int i = 0; i < 8; i++) begin
        ones = d[j][i] ? ones + 1 : 0;
        if (ones == 6) begin
          n++;
          ones = 0;
        end
      end
    end
    return n;
  endfunction

  // Upstream byte source: advances on each tx_data_get.
  initial begin : upstream
    int idx;
    int seen;
    idx = 0;
    seen = 0;
    forever begin
      @(posedge clk);
      #1;
      if (pkt_seq != seen) begin
        seen = pkt_seq;
        idx = 0;
      end else if (tx_data_get) begin
        idx++;
      end
      tx_data = mem[idx % 64];
      tx_data_avail = (idx < up_n);
    end
  end

  initial forever begin
    @(negedge clk);
    if (tx_pkt_end) end_cnt++;
  end

  // Line monitor: NRZI decode, destuff, assemble bytes, check EOP and figures.
  initial begin : monitor
    bit active;
    int cyc, en_clks, gets, se0, jseen, nbits, nbytes, ones, stuffs;
    logic prev_dp, b;
    logic [7:0] sh;
    exp_pkt_t e;
    active = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        active = 1'b0;
      end else begin
        if (!active && usb_tx_en) begin
          active = 1'b1;
          cyc = 0; en_clks = 0; gets = 0; se0 = 0; jseen = 0;
          nbits = 0; nbytes = 0; ones = 0; stuffs = 0;
          prev_dp = 1'b1;
          sh = 8'h00;
        end
        if (active) begin
          if (!usb_tx_en) begin
            active = 1'b0;
            if (!abort_mode) begin
              if (pkt_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_pkt actual=1 required=0 at %0t", $time);
              end else begin
                e = pkt_q.pop_front();
                chk("pkt_nbytes", nbytes, e.nbytes);
                chk("pkt_partial_bits", nbits, 0);
                chk("eop_se0_bits", se0, 2);
                chk("eop_j_bits", jseen, 1);
                chk("pkt_stuffs", stuffs, e.stuffs);
                chk("pkt_en_clks", en_clks, e.clks);
                chk("pkt_gets", gets, e.gets);
                chk("pkt_end_at_en_fall", int'(tx_pkt_end), 1);
              end
            end
          end else begin
            en_clks++;
            if (tx_data_get) gets++;
            if (cyc % Cpb == 1) begin
              if (!usb_dp_tx && !usb_dn_tx) begin
                se0++;
              end else if (se0 > 0) begin
                jseen++;
              end else begin
                b = (usb_dp_tx == prev_dp);
                prev_dp = usb_dp_tx;
                if (ones == 6) begin
                  if (!abort_mode) chk("stuff_bit_zero", int'(b), 0);
                  ones = 0;
                  stuffs++;
                end else begin
                  ones = b ? ones + 1 : 0;
                  sh = {b, sh[7:1]};
                  nbits++;
                  if (nbits == 8) begin
                    nbits = 0;
                    nbytes++;
                    if (!abort_mode) begin
                      if (byte_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL extra_byte actual=%0h required=none at %0t", sh, $time);
                      end else begin
                        chk("byte", int'(sh), int'(byte_q.pop_front()));
                      end
                    end
                  end
                end
              end
            end
            cyc++;
          end
        end
      end
    end
  end

  // Queue expectations, start a packet, optionally disturb it, wait for the end.
  task automatic send_pkt(input logic [3:0] pid, input logic [7:0] pid_byte, input int n,
                          input bit abort, input bit mid_start);
    logic [7:0] pk[$];
    logic [7:0] pl[$];
    logic [15:0] c;
    logic [7:0] c0, c1;
    bit is_data;
    int st, cnt, ends0;
    is_data = (pid[1:0] == 2'b11);
    pk.push_back(pid_byte);
    if (is_data) begin
      for (int i = 0; i < n; i++) pl.push_back(mem[i]);
      c = crc16_model(pl);
      for (int i = 0; i < 8; i++) begin
        c0[i] = ~c[15 - i];
        c1[i] = ~c[7 - i];
      end
      foreach (pl[i]) pk.push_back(pl[i]);
      pk.push_back(c0);
      pk.push_back(c1);
    end
    st = count_stuffs(pk);
    if (!abort) begin
      byte_q.push_back(8'h80);
      foreach (pk[i]) byte_q.push_back(pk[i]);
      pkt_q.push_back('{nbytes: pk.size() + 1, gets: (is_data ? n : 0),
                        clks: ((pk.size() + 1) * 8 + st + 3) * Cpb, stuffs: st});
      exp_ends++;
    end
    up_n = n;
    pkt_seq++;
    @(negedge clk);
    tx_pid = pid;
    tx_pkt_start = 1'b1;
    @(negedge clk);
    tx_pkt_start = 1'b0;
    chk("start_tx_en", int'(usb_tx_en), 1);
    chk("start_line_k", int'({usb_dp_tx, usb_dn_tx}), int'(LineK));
    chk("start_busy", int'(tx_busy), 1);
    if (abort) begin
      repeat (150) @(negedge clk);
      ends0 = end_cnt;
      reset = 1'b1;
      #1;
      chk("rst_tx_en", int'(usb_tx_en), 0);
      chk("rst_line_j", int'({usb_dp_tx, usb_dn_tx}), int'(LineJ));
      chk("rst_busy", int'(tx_busy), 0);
      chk("rst_get", int'(tx_data_get), 0);
      repeat (3) @(negedge clk);
      reset = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_no_pkt_end", end_cnt, ends0);
      return;
    end
    if (mid_start) begin
      repeat (100) @(negedge clk);
      tx_pid = PidAck;
      tx_pkt_start = 1'b1;
      chk("mid_start_busy", int'(tx_busy), 1);
      @(negedge clk);
      tx_pkt_start = 1'b0;
      chk("mid_start_still_busy", int'(tx_busy), 1);
    end
    cnt = 0;
    while (!tx_pkt_end && cnt < 4000) begin
      @(negedge clk);
      cnt++;
    end
    if (!tx_pkt_end) begin
      total++;
      bad++;
      $display("FAIL pkt_end_timeout actual=0 required=1 at %0t", $time);
    end
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog actual=running required=finished at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    for (int i = 0; i < 64; i++) mem[i] = 8'h00;
    repeat (3) @(negedge clk);
    chk("reset_tx_en", int'(usb_tx_en), 0);
    chk("reset_dp", int'(usb_dp_tx), 1);
    chk("reset_dn", int'(usb_dn_tx), 0);
    chk("reset_get", int'(tx_data_get), 0);
    chk("reset_end", int'(tx_pkt_end), 0);
    chk("reset_busy", int'(tx_busy), 0);
    reset = 1'b0;
    repeat (3) @(negedge clk);

    // ACK: 0xD2, 19 bit times = 76 clks, no fetches.
    send_pkt(PidAck, 8'hD2, 0, 1'b0, 1'b0);
    repeat (4) @(negedge clk);

    // Zero-length DATA1: 0x4B then CRC 0x00 0x00.
    send_pkt(PidData1, 8'h4B, 0, 1'b0, 1'b0);
    repeat (4) @(negedge clk);

    // Stuffing: DATA0 0xFF 0xFF.
    mem[0] = 8'hFF;
    mem[1] = 8'hFF;
    send_pkt(PidData0, 8'hC3, 2, 1'b0, 1'b0);
    repeat (4) @(negedge clk);

    // 32 bytes 0x00..0x1F, with an ignored start mid-packet.
    for (int i = 0; i < 32; i++) mem[i] = 8'(i);
    send_pkt(PidData0, 8'hC3, 32, 1'b0, 1'b1);

    // Back-to-back: next start in the cycle after tx_pkt_end.
    send_pkt(PidAck, 8'hD2, 0, 1'b0, 1'b0);
    send_pkt(PidStall, 8'h1E, 0, 1'b0, 1'b0);
    repeat (4) @(negedge clk);

    // Reset mid-DATA, then a NAK.
    for (int i = 0; i < 8; i++) mem[i] = 8'hA0 + 8'(i);
    abort_mode = 1'b1;
    send_pkt(PidData1, 8'h4B, 8, 1'b1, 1'b0);
    abort_mode = 1'b0;
    repeat (2) @(negedge clk);
    send_pkt(PidNak, 8'h5A, 0, 1'b0, 1'b0);
    repeat (6) @(negedge clk);

    chk("end_count", end_cnt, exp_ends);
    chk("bytes_left", byte_q.size(), 0);
    chk("pkts_left", pkt_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
